// File: rtl/mem_unit_hs.sv
// mem_unit_hs: request/ready memory with programmable wait states before each access.
// Define MEM_UNIT_HS_PARITY_EN to store an even-parity bit per word and flag read errors.
module mem_unit_hs #(
    parameter int word_size   = 8,
    parameter int addr_size   = 8,
    parameter int wait_states = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 write,
    input  logic [addr_size-1:0] address,
    input  logic [word_size-1:0] data_in,
    output logic [word_size-1:0] data_out,
    output logic                 ready,
    output logic                 busy,
    output logic                 err
);
`ifdef MEM_UNIT_HS_PARITY_EN
    localparam int mw = word_size + 1;
`else
    localparam int mw = word_size;
`endif
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, next;
    logic [3:0] cnt;
    logic wr_q;
    logic [addr_size-1:0] addr_q;
    logic [word_size-1:0] data_q;
    logic [mw-1:0] mem [2**addr_size];
    logic [mw-1:0] word_in, word_rd;
    logic done;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state == IDLE ? (req ? WAIT : IDLE) : (cnt == 4'd0 ? IDLE : WAIT);
        done = state == WAIT && cnt == 4'd0;
        busy = state == WAIT;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt      <= '0;
            ready    <= 1'b0;
            data_out <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            ready <= done;
            if (state == IDLE && req) begin
                wr_q   <= write;
                addr_q <= address;
                data_q <= data_in;
                cnt    <= 4'(wait_states);
            end else if (state == WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (done && !wr_q) data_out <= word_rd[word_size-1:0];
        end
    // Array has no reset so contents survive rst; an aborted write never reaches done.
    always_ff @(posedge clk)
        if (done && wr_q) mem[addr_q] <= word_in;
    assign word_rd = mem[addr_q];
`ifdef MEM_UNIT_HS_PARITY_EN
    assign word_in = {^data_q, data_q};
    always_ff @(posedge clk or posedge rst)
        if (rst) err <= 1'b0;
        else if (done) err <= wr_q ? 1'b0 : ^word_rd;
`else
    assign word_in = data_q;
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_unit_hs.sv
// tb_mem_unit_hs: directed checks of mem_unit_hs with wait_states 2 (u0) and 0 (u1).
module tb_mem_unit_hs;
    logic clk = 1'b0, rst = 1'b1;
    logic req = 1'b0, write = 1'b0;
    logic [7:0] address = '0, data_in = '0, data_out;
    logic ready, busy, err;
    logic req1 = 1'b0, write1 = 1'b0;
    logic [7:0] address1 = '0, data_in1 = '0, data_out1;
    logic ready1, busy1, err1;
    int checks = 0, failures = 0;
    int lat, pulses;
    always #5 clk = ~clk;
    mem_unit_hs #(.word_size(8), .addr_size(8), .wait_states(2)) u0 (
        .clk(clk), .rst(rst), .req(req), .write(write), .address(address), .data_in(data_in),
        .data_out(data_out), .ready(ready), .busy(busy), .err(err));
    mem_unit_hs #(.word_size(8), .addr_size(8), .wait_states(0)) u1 (
        .clk(clk), .rst(rst), .req(req1), .write(write1), .address(address1), .data_in(data_in1),
        .data_out(data_out1), .ready(ready1), .busy(busy1), .err(err1));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Issues one access on u0, then perturbs the inputs right after acceptance.
    task automatic acc(input string tag, input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] aa, input logic [7:0] da);
        write = w; address = a; data_in = d; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; address = aa; data_in = da; write = ~w;
        chk({tag, "_busy"}, busy, 1);
        lat = 21;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_lat"}, lat, 3);
        @(posedge clk); #1;
        chk({tag, "_ready_1cyc"}, ready, 0);
    endtask
    task automatic wr1(input logic [7:0] a, input logic [7:0] d);
        write1 = 1'b1; address1 = a; data_in1 = d; req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask
    initial begin
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        acc("wr10", 1'b1, 8'h10, 8'hA5, 8'h10, 8'hA5);
        chk("wr10_dout_kept", data_out, 8'h00);
        acc("rd10", 1'b0, 8'h10, 8'h00, 8'h20, 8'h00);
        chk("rd10_dout", data_out, 8'hA5);
        chk("rd10_err", err, 0);
        acc("wr20", 1'b1, 8'h20, 8'h3C, 8'h20, 8'h3C);
        acc("rd20", 1'b0, 8'h20, 8'h00, 8'h20, 8'h00);
        chk("rd20_dout", data_out, 8'h3C);
        acc("rd10b", 1'b0, 8'h10, 8'h00, 8'h20, 8'h00);
        chk("addr_change_dout", data_out, 8'hA5);
        acc("wr40", 1'b1, 8'h40, 8'h11, 8'h41, 8'hFF);
        acc("rd40", 1'b0, 8'h40, 8'h00, 8'h41, 8'h00);
        chk("data_change_dout", data_out, 8'h11);
        write = 1'b1; address = 8'h10; data_in = 8'h77; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 0);
        chk("abort_dout", data_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        chk("abort_no_ready", pulses, 0);
        acc("rd10_after_abort", 1'b0, 8'h10, 8'h00, 8'h10, 8'h00);
        chk("abort_old_data", data_out, 8'hA5);
        wr1(8'h01, 8'h5A);
        wr1(8'h02, 8'hC3);
        write1 = 1'b0; address1 = 8'h01; req1 = 1'b1;
        @(posedge clk); #1;
        chk("b2b_k1_ready", ready1, 0);
        @(posedge clk); #1;
        chk("b2b_k2_ready", ready1, 1);
        chk("b2b_k2_dout", data_out1, 8'h5A);
        address1 = 8'h02;
        @(posedge clk); #1;
        chk("b2b_k3_ready", ready1, 0);
        @(posedge clk); #1;
        chk("b2b_k4_ready", ready1, 1);
        chk("b2b_k4_dout", data_out1, 8'hC3);
        req1 = 1'b0;
`ifdef MEM_UNIT_HS_PARITY_EN
        acc("wr30", 1'b1, 8'h30, 8'h0F, 8'h30, 8'h0F);
        u0.mem[8'h30][0] = ~u0.mem[8'h30][0];
        acc("rd30", 1'b0, 8'h30, 8'h00, 8'h30, 8'h00);
        chk("par_err_set", err, 1);
        acc("wr31", 1'b1, 8'h31, 8'h22, 8'h31, 8'h22);
        chk("par_err_clr", err, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
